// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller slice: FSM state encoding
// and the architectural source limit.
package irq_pkg;

  localparam int MAX_SRC = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WFI  = 2'b01,
    TRAP = 2'b11
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan from the top down so the last hit, the lowest index, sticks.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-level interrupt controller: level/edge source capture, priority
// selection and the IDLE/WFI/TRAP sequencing seen by the issue stage.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] edge_mode_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  input  logic               gie_i,
  input  logic               wfi_i,
  input  logic               mret_i,
  output logic               trap_en_o,
  output logic [ID_W-1:0]    trap_id_o,
  output logic               trap_end_o,
  output logic               wfi_sleep_o,
  output logic               pc_hold_o,
  output logic [NUM_SRC-1:0] pending_o
);

  irq_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [ID_W-1:0]    trap_id_q;

  logic [NUM_SRC-1:0] rise, pending, eligible, clr;
  logic [ID_W-1:0]    sel_id;
  logic               any_elig, take, trap_en, trap_end;

  assign rise     = irq_i & ~irq_q & edge_mode_i;
  assign pending  = (irq_i & ~edge_mode_i) | (edge_pend_q & edge_mode_i);
  assign eligible = pending & src_en_i;
  assign take     = any_elig & gie_i;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .valid_o (any_elig),
    .id_o    (sel_id)
  );

  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      unique case (state_q)
        IDLE: begin
          if (take)       state_d = TRAP;
          else if (wfi_i) state_d = WFI;
        end
        WFI: begin
          if (take)          state_d = TRAP;
          else if (any_elig) state_d = IDLE;
        end
        TRAP: begin
          if (mret_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign trap_en  = (state_d == TRAP) && (state_q != TRAP);
  assign trap_end = (state_q == TRAP) && (state_d == IDLE);

  // A fresh rise in the entry cycle re-arms the bit, so set beats clear.
  assign clr         = trap_en ? (NUM_SRC'(1) << sel_id) : '0;
  assign edge_pend_d = (edge_pend_q & ~clr) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      edge_pend_q <= '0;
      trap_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_i;
      edge_pend_q <= edge_pend_d;
      if (trap_en) trap_id_q <= sel_id;
    end
  end

  // Combinational outputs are masked so nothing escapes while reset is held.
  assign trap_en_o   = trap_en & ~rst;
  assign trap_end_o  = trap_end & ~rst;
  assign trap_id_o   = rst ? '0 : (trap_en ? sel_id : trap_id_q);
  assign wfi_sleep_o = (state_q == WFI);
  assign pc_hold_o   = (state_d == WFI) & ~rst;
  assign pending_o   = pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: trap entry/exit events go through a cycle-stamped
// scoreboard, status outputs are compared directly against hand-computed values.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [3:0] irq;
  logic [3:0] edgeMode;
  logic [3:0] srcEn;
  logic       gie;
  logic       wfi;
  logic       mret;
  logic       trapEn;
  logic [1:0] trapId;
  logic       trapEnd;
  logic       wfiSleep;
  logic       pcHold;
  logic [3:0] pending;

  typedef struct {
    bit         isEnd;
    logic [1:0] id;
    int         cyc;
  } event_t;

  event_t expQ[$];
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;

  irq_ctrl #(.NUM_SRC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .irq_i       (irq),
    .edge_mode_i (edgeMode),
    .src_en_i    (srcEn),
    .gie_i       (gie),
    .wfi_i       (wfi),
    .mret_i      (mret),
    .trap_en_o   (trapEn),
    .trap_id_o   (trapId),
    .trap_end_o  (trapEnd),
    .wfi_sleep_o (wfiSleep),
    .pc_hold_o   (pcHold),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic applyStimulus(input logic [3:0] irqV, input logic mretV = 1'b0,
                               input logic wfiV = 1'b0, input logic stallV = 1'b0,
                               input logic gieV = 1'b1, input logic [3:0] enV = 4'hF);
    @(posedge clk);
    #1;
    irq   = irqV;
    mret  = mretV;
    wfi   = wfiV;
    stall = stallV;
    gie   = gieV;
    srcEn = enV;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectTrap(input logic [1:0] id);
    expQ.push_back('{isEnd: 1'b0, id: id, cyc: cyc});
  endtask

  task automatic expectEnd();
    expQ.push_back('{isEnd: 1'b1, id: 2'd0, cyc: cyc});
  endtask

  task automatic popCheck(input bit isEnd, input logic [1:0] id);
    event_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected_event: got %s id=%0d at cycle %0d, expected none",
               isEnd ? "trap_end" : "trap_en", id, cyc);
    end else begin
      e = expQ.pop_front();
      if (e.isEnd != isEnd || (!isEnd && e.id != id) || e.cyc != cyc) begin
        miscompares++;
        $display("[TB] FAIL event: got %s id=%0d cycle %0d, expected %s id=%0d cycle %0d",
                 isEnd ? "trap_end" : "trap_en", id, cyc,
                 e.isEnd ? "trap_end" : "trap_en", e.id, e.cyc);
      end
    end
  endtask

  // Monitor samples on the falling edge, including while reset is held.
  always @(negedge clk) begin
    if (trapEn === 1'b1)  popCheck(1'b0, trapId);
    if (trapEnd === 1'b1) popCheck(1'b1, 2'd0);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; irq = 4'b0110; edgeMode = 4'b0000;
    srcEn = 4'hF; gie = 1'b1; wfi = 1'b0; mret = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_trap_en",   32'(trapEn),   32'd0);
    checkOutput("rst_trap_id",   32'(trapId),   32'd0);
    checkOutput("rst_trap_end",  32'(trapEnd),  32'd0);
    checkOutput("rst_wfi_sleep", 32'(wfiSleep), 32'd0);
    checkOutput("rst_pc_hold",   32'(pcHold),   32'd0);
    checkOutput("rst_pending",   32'(pending),  32'h6);
    @(posedge clk);
    #1;
    rst = 1'b0;
    irq = 4'b0000;

    // Level sources 1 and 2: lowest index wins, re-entry after mret.
    applyStimulus(4'b0110); expectTrap(2'd1);
    checkOutput("lvl_pending", 32'(pending), 32'h6);
    applyStimulus(4'b0110);
    checkOutput("trap_id_hold", 32'(trapId), 32'd1);
    applyStimulus(4'b0110, 1'b1); expectEnd();
    applyStimulus(4'b0110); expectTrap(2'd1);
    applyStimulus(4'b0000, 1'b1); expectEnd();

    // Edge source 3 pulses during a trap and is serviced after mret.
    edgeMode = 4'b1000;
    applyStimulus(4'b0010); expectTrap(2'd1);
    applyStimulus(4'b1010);
    applyStimulus(4'b0010);
    checkOutput("edge_pend_set", 32'(pending), 32'hA);
    applyStimulus(4'b0000);
    checkOutput("edge_pend_held", 32'(pending), 32'h8);
    applyStimulus(4'b0000, 1'b1); expectEnd();
    applyStimulus(4'b0000); expectTrap(2'd3);
    applyStimulus(4'b0000);
    checkOutput("edge_pend_clr", 32'(pending), 32'h0);
    checkOutput("edge_trap_id",  32'(trapId),  32'd3);
    applyStimulus(4'b0000, 1'b1); expectEnd();

    // WFI: wake without trap when globally disabled, then with trap.
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("wfi_pc_hold",     32'(pcHold),   32'd1);
    checkOutput("wfi_sleep_early", 32'(wfiSleep), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wfi_sleep",    32'(wfiSleep), 32'd1);
    checkOutput("wfi_pc_hold2", 32'(pcHold),   32'd1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wake_pc_hold", 32'(pcHold),   32'd0);
    checkOutput("wake_sleep",   32'(wfiSleep), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("woke_idle", 32'(wfiSleep), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000);
    checkOutput("wfi_sleep_again", 32'(wfiSleep), 32'd1);
    applyStimulus(4'b0100); expectTrap(2'd2);
    checkOutput("wake_trap_pc_hold", 32'(pcHold), 32'd0);
    applyStimulus(4'b0000, 1'b1); expectEnd();

    // Stall freezes entry and exit.
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0001); expectTrap(2'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b1); expectEnd();

    // Edge source 0 re-rises on the very edge that enters its trap.
    edgeMode = 4'b1001;
    applyStimulus(4'b0001);
    checkOutput("edge_not_yet", 32'(pending), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("edge_pend0", 32'(pending), 32'h1);
    applyStimulus(4'b0001); expectTrap(2'd0);
    applyStimulus(4'b0000);
    checkOutput("set_wins", 32'(pending), 32'h1);
    applyStimulus(4'b0000, 1'b1); expectEnd();
    applyStimulus(4'b0000); expectTrap(2'd0);
    applyStimulus(4'b0000, 1'b1); expectEnd();
    checkOutput("set_wins_clr", 32'(pending), 32'h0);

    // Disabled edge source keeps its pending bit and is taken once enabled.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1110);
    checkOutput("masked_pend", 32'(pending), 32'h1);
    applyStimulus(4'b0000); expectTrap(2'd0);
    applyStimulus(4'b0000, 1'b1); expectEnd();

    // Reset in the middle of a trap aborts without trap_end.
    applyStimulus(4'b0100); expectTrap(2'd2);
    applyStimulus(4'b0100);
    rst  = 1'b1;
    mret = 1'b1;
    #1;
    checkOutput("abort_trap_en",  32'(trapEn),   32'd0);
    checkOutput("abort_trap_id",  32'(trapId),   32'd0);
    checkOutput("abort_trap_end", 32'(trapEnd),  32'd0);
    checkOutput("abort_sleep",    32'(wfiSleep), 32'd0);
    checkOutput("abort_pc_hold",  32'(pcHold),   32'd0);
    checkOutput("abort_pending",  32'(pending),  32'h4);
    @(posedge clk);
    #2;
    checkOutput("abort_trap_end2", 32'(trapEnd), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mret = 1'b0;
    irq  = 4'b0000;
    repeat (3) applyStimulus(4'b0000);

    while (expQ.size() > 0) begin
      event_t e;
      e = expQ.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_event: got nothing, expected %s id=%0d at cycle %0d",
               e.isEnd ? "trap_end" : "trap_en", e.id, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of interrupt sources, legal range 1..32.
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_SRC) with a minimum of 1: width of the source index.
REQ-003 SHALL have port clk  in  1: clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port stall_i  in  1: bus/pipeline stall; while high, state transitions and pending clears are frozen.
REQ-006 SHALL have port irq_i  in  NUM_SRC: raw interrupt requests (DMA, WDT, ...), synchronous to clk.
REQ-007 SHALL have port edge_mode_i  in  NUM_SRC: per-source mode, 1 = rising-edge, 0 = level.
REQ-008 SHALL have port src_en_i  in  NUM_SRC: per-source enable (mie bits).
REQ-009 SHALL have port gie_i  in  1: global enable (mstatus.MIE).
REQ-010 SHALL have port wfi_i  in  1: decoded WFI in the issuing stage.
REQ-011 SHALL have port mret_i  in  1: decoded MRET in the issuing stage.
REQ-012 SHALL have port trap_en_o  out  1: one-cycle pulse on trap entry.
REQ-013 SHALL have port trap_id_o  out  ID_W: source index being serviced.
REQ-014 SHALL have port trap_end_o  out  1: one-cycle pulse on trap exit.
REQ-015 SHALL have port wfi_sleep_o  out  1: core is sleeping in WFI.
REQ-016 SHALL have port pc_hold_o  out  1: freeze PC advance.
REQ-017 SHALL have port pending_o  out  NUM_SRC: effective pending vector.

Function
REQ-018 Level source i: pending[i] SHALL equal irq_i[i], combinationally and with no latch.
REQ-019 Edge source i: pending[i] SHALL be set on the cycle after irq_i[i] goes from 0 to 1, as seen by a registered copy irq_q.
REQ-020 Edge source i: pending[i] SHALL clear on the clock edge that enters TRAP with trap_id = i; if a new rise arrives in the same cycle, set SHALL win.
REQ-021 eligible SHALL be pending & src_en_i; take SHALL be (|eligible) & gie_i.
REQ-022 Priority: the lowest-index eligible source SHALL be selected as sel_id.
REQ-023 FSM SHALL have states IDLE, WFI, TRAP; no transition SHALL occur while stall_i = 1.
REQ-024 From IDLE: take -> TRAP; otherwise wfi_i -> WFI; otherwise stay in IDLE. take SHALL have priority over wfi_i.
REQ-025 From WFI: take -> TRAP; (|eligible) with gie_i = 0 -> IDLE (resume without trap); otherwise stay in WFI.
REQ-026 From TRAP: mret_i -> IDLE; no nesting, so new requests remain pending only.
REQ-027 trap_en_o SHALL be 1 exactly in the cycle where the next state is TRAP and the current state is not TRAP.
REQ-028 trap_id_o SHALL be combinational sel_id while trap_en_o is high, and SHALL equal the value captured into a register on TRAP entry for the whole TRAP stay.
REQ-029 trap_end_o SHALL be 1 exactly in the cycle where the current state is TRAP and the next state is IDLE.
REQ-030 wfi_sleep_o SHALL be 1 whenever the current state is WFI.
REQ-031 pc_hold_o SHALL be 1 whenever the next state is WFI, and 0 on the wake cycle.
REQ-032 Latency: a level source with enables set SHALL raise trap_en_o in the same cycle; an edge source SHALL raise it 1 cycle after the rising edge, provided stall_i = 0.
REQ-033 A source enabled while already pending SHALL be taken in that cycle; a source disabled while pending SHALL keep its edge-pending bit.

Reset
REQ-034 On rst: state = IDLE, irq_q = 0, pending latches = 0, and the trap_id register = 0.
REQ-035 During reset all outputs SHALL be 0, except pending_o, which reflects level sources.
REQ-036 Reset asserted in any state, including mid-TRAP or mid-WFI, SHALL abort to IDLE with no trap_end_o pulse.

Structure
REQ-037 Package irq_pkg SHALL hold the state enum irq_state_t (IDLE=2'b00, WFI=2'b01, TRAP=2'b11) and the maximum-source constant 32.
REQ-038 The lowest-index priority encoder SHALL be sub-module irq_prio_enc (parameter NUM_SRC; outputs valid and id).

Verification
REQ-039 NUM_SRC=4, all enables set, level irq_i=4'b0110 -> trap_en_o pulses, trap_id_o=1; mret_i -> trap_end_o pulses, state IDLE; trap re-enters next cycle with id 1 if irq_i is still 0110.
REQ-040 Edge source 3 pulses for 1 cycle while in TRAP -> pending_o[3]=1 is held; after mret_i, trap_en_o fires with id 3 and pending_o[3] clears.
REQ-041 wfi_i in IDLE -> pc_hold_o=1 and wfi_sleep_o=1 from the next cycle; irq_i[2] rises with gie_i=0 -> returns to IDLE with no trap_en_o; repeating with gie_i=1 -> trap_en_o with id 2.
REQ-042 stall_i=1 for 5 cycles with irq_i[0] asserted -> no trap_en_o; trap_en_o in the first cycle after stall_i drops.
REQ-043 Edge rise on source 0 in the same cycle as TRAP entry for source 0 -> pending_o[0] is still 1 afterwards.
REQ-044 rst asserted mid-TRAP -> all outputs 0 and trap_end_o never pulses.
